// File: rtl/end_screen_ctrl.sv
// End-of-game page sequencer: captures outcome/score, converts score to BCD, drives page/blink/restart.
// Define END_AUTO_RESTART_EN to leave the end page automatically after AUTO_FRAMES frames.
module end_screen_ctrl #(
    parameter int unsigned SCORE_W      = 10,
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned HOLD_FRAMES  = 180,
    parameter int unsigned BLINK_FRAMES = 30,
    parameter int unsigned AUTO_FRAMES  = 600
) (
    input  logic                  vga_clk_i,
    input  logic                  sys_rst_ni,
    input  logic                  frame_start_i,
    input  logic                  game_over_i,
    input  logic                  game_won_i,
    input  logic [SCORE_W-1:0]    score_i,
    input  logic                  key_confirm_i,
    output logic [1:0]            page_sel_o,
    output logic [4*DIGITS-1:0]   score_bcd_o,
    output logic                  bcd_valid_o,
    output logic                  text_visible_o,
    output logic                  restart_req_o
);

    localparam int unsigned BcdW    = 4 * DIGITS;
    localparam int unsigned CntMax  = (HOLD_FRAMES > AUTO_FRAMES) ? HOLD_FRAMES : AUTO_FRAMES;
    localparam int unsigned FrameW  = $clog2(CntMax + 1);
    localparam int unsigned BlinkW  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned BitCntW = (SCORE_W > 1) ? $clog2(SCORE_W) : 1;
    localparam int unsigned BcdMax  = (10 ** DIGITS) - 1;

    localparam logic [FrameW-1:0]  HoldCnt   = FrameW'(HOLD_FRAMES);
    localparam logic [BlinkW-1:0]  BlinkLast = BlinkW'(BLINK_FRAMES - 1);
    localparam logic [BitCntW-1:0] BitLast   = BitCntW'(SCORE_W - 1);

    typedef enum logic [2:0] {
        StPlay,
        StCapture,
        StConvert,
        StArm,
        StShow,
        StRelease
    } state_e;

    state_e               state_q, state_d;
    logic                 win_q, win_d;
    logic                 sat_q, sat_d;
    logic [SCORE_W-1:0]   shreg_q, shreg_d;
    logic [BcdW-1:0]      bcd_q, bcd_d;
    logic [BcdW-1:0]      bcd_adj;
    logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FrameW-1:0]    frame_cnt_q, frame_cnt_d;
    logic [BlinkW-1:0]    blink_cnt_q, blink_cnt_d;
    logic                 key_q;
    logic                 key_rise;
    logic                 auto_hit;
    logic [1:0]           page_sel_q, page_sel_d;
    logic [BcdW-1:0]      score_bcd_q, score_bcd_d;
    logic                 bcd_valid_q, bcd_valid_d;
    logic                 text_vis_q, text_vis_d;
    logic                 restart_q, restart_d;

    assign key_rise = key_confirm_i & ~key_q;

`ifdef END_AUTO_RESTART_EN
    localparam logic [FrameW-1:0] AutoCnt = FrameW'(AUTO_FRAMES);
    assign auto_hit = (frame_cnt_q >= AutoCnt);
`else
    assign auto_hit = 1'b0;
`endif

    // Double-dabble correction: any nibble >= 5 gets +3 before the shift.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        sat_d       = sat_q;
        shreg_d     = shreg_q;
        bcd_d       = bcd_q;
        bit_cnt_d   = bit_cnt_q;
        frame_cnt_d = frame_cnt_q;
        blink_cnt_d = blink_cnt_q;
        page_sel_d  = page_sel_q;
        score_bcd_d = score_bcd_q;
        bcd_valid_d = bcd_valid_q;
        text_vis_d  = text_vis_q;

        case (state_q)
            StPlay: begin
                // Outcome is taken from the frame_start sample; win beats lose.
                if (frame_start_i && (game_over_i || game_won_i)) begin
                    win_d   = game_won_i;
                    state_d = StCapture;
                end
            end
            StCapture: begin
                shreg_d     = score_i;
                sat_d       = (32'(score_i) > BcdMax);
                bcd_d       = '0;
                bit_cnt_d   = '0;
                bcd_valid_d = 1'b0;
                state_d     = StConvert;
            end
            StConvert: begin
                bcd_d     = (bcd_adj << 1) | BcdW'(shreg_q[SCORE_W-1]);
                shreg_d   = shreg_q << 1;
                bit_cnt_d = bit_cnt_q + 1'b1;
                if (bit_cnt_q == BitLast) begin
                    score_bcd_d = sat_q ? {DIGITS{4'h9}} : bcd_d;
                    state_d     = StArm;
                end
            end
            StArm: begin
                if (frame_start_i) begin
                    page_sel_d  = win_q ? 2'd2 : 2'd1;
                    bcd_valid_d = 1'b1;
                    frame_cnt_d = '0;
                    blink_cnt_d = '0;
                    text_vis_d  = 1'b1;
                    state_d     = StShow;
                end
            end
            StShow: begin
                if (frame_start_i) begin
                    if (frame_cnt_q != '1) begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                    if (blink_cnt_q == BlinkLast) begin
                        blink_cnt_d = '0;
                        text_vis_d  = ~text_vis_q;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                // Only a fresh press after the hold counts; a key held through it never rises.
                if ((key_rise && (frame_cnt_q >= HoldCnt)) || auto_hit) begin
                    state_d = StRelease;
                end
            end
            StRelease: begin
                if (frame_start_i && !game_over_i && !game_won_i) begin
                    page_sel_d  = 2'd0;
                    bcd_valid_d = 1'b0;
                    text_vis_d  = 1'b1;
                    state_d     = StPlay;
                end
            end
            default: state_d = StPlay;
        endcase

        restart_d = (state_d == StRelease) && (state_q != StRelease);
    end

    always_ff @(posedge vga_clk_i or negedge sys_rst_ni) begin
        if (!sys_rst_ni) begin
            state_q     <= StPlay;
            win_q       <= 1'b0;
            sat_q       <= 1'b0;
            shreg_q     <= '0;
            bcd_q       <= '0;
            bit_cnt_q   <= '0;
            frame_cnt_q <= '0;
            blink_cnt_q <= '0;
            key_q       <= 1'b0;
            page_sel_q  <= 2'd0;
            score_bcd_q <= '0;
            bcd_valid_q <= 1'b0;
            text_vis_q  <= 1'b1;
            restart_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            sat_q       <= sat_d;
            shreg_q     <= shreg_d;
            bcd_q       <= bcd_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_cnt_q <= frame_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            key_q       <= key_confirm_i;
            page_sel_q  <= page_sel_d;
            score_bcd_q <= score_bcd_d;
            bcd_valid_q <= bcd_valid_d;
            text_vis_q  <= text_vis_d;
            restart_q   <= restart_d;
        end
    end

    assign page_sel_o     = page_sel_q;
    assign score_bcd_o    = score_bcd_q;
    assign bcd_valid_o    = bcd_valid_q;
    assign text_visible_o = text_vis_q;
    assign restart_req_o  = restart_q;

endmodule

// File: tb/tb_end_screen_ctrl.sv
// Randomized self-checking bench for end_screen_ctrl against a frame-level behavioural model.
module tb_end_screen_ctrl;

    localparam int unsigned ScoreW = 10;
    localparam int unsigned Digits = 4;
    localparam int unsigned Hold   = 4;
    localparam int unsigned Blink  = 2;
    localparam int unsigned Auto   = 8;

    logic              clk;
    logic              rst_n;
    logic              frame_start;
    logic              game_over;
    logic              game_won;
    logic [ScoreW-1:0] score;
    logic              key;
    logic [1:0]        page_sel;
    logic [15:0]       score_bcd;
    logic              bcd_valid;
    logic              text_visible;
    logic              restart_req;

    int          n_vec;
    int          n_err;
    int          restart_cnt;
    logic [15:0] exp_bcd;

    end_screen_ctrl #(
        .SCORE_W      (ScoreW),
        .DIGITS       (Digits),
        .HOLD_FRAMES  (Hold),
        .BLINK_FRAMES (Blink),
        .AUTO_FRAMES  (Auto)
    ) u_dut (
        .vga_clk_i      (clk),
        .sys_rst_ni     (rst_n),
        .frame_start_i  (frame_start),
        .game_over_i    (game_over),
        .game_won_i     (game_won),
        .score_i        (score),
        .key_confirm_i  (key),
        .page_sel_o     (page_sel),
        .score_bcd_o    (score_bcd),
        .bcd_valid_o    (bcd_valid),
        .text_visible_o (text_visible),
        .restart_req_o  (restart_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse-width sensitive: a 1-cycle pulse is seen on exactly one falling edge.
    always @(negedge clk) if (restart_req === 1'b1) restart_cnt++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected end of run");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] bcd_of(input int unsigned s);
        logic [15:0] r;
        int unsigned v;
        if (s > 9999) return 16'h9999;
        r = '0;
        v = s;
        for (int d = 0; d < 4; d++) begin
            r[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic blink_of(input int k);
        return ((k / Blink) % 2) == 0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // From PLAY through conversion and ARM; ends just after frame 0 of the end page.
    task automatic enter_end(input logic [ScoreW-1:0] sc, input logic ov, input logic wn,
                             input bit fs_on_last);
        for (int i = 0; i < 4; i++) begin
            game_over = 1'($urandom);
            game_won  = 1'($urandom);
            tick();
        end
        score     = sc;
        game_over = ov;
        game_won  = wn;
        pulse_frame();
        tick();
        score = ScoreW'($urandom);
        for (int c = 3; c <= 11; c++) begin
            game_over   = 1'($urandom);
            game_won    = 1'($urandom);
            frame_start = (c < 11) ? 1'($urandom) : 1'b0;
            tick();
        end
        frame_start = 1'b0;
        check_val("bcd_hold", 32'(score_bcd), 32'(exp_bcd));
        check_val("bcd_inval", 32'(bcd_valid), 32'd0);
        exp_bcd     = bcd_of(int'(sc));
        frame_start = fs_on_last;
        tick();
        frame_start = 1'b0;
        check_val("bcd_value", 32'(score_bcd), 32'(exp_bcd));
        repeat (1 + $urandom_range(2)) tick();
        check_val("arm_wait", 32'(page_sel), 32'd0);
        pulse_frame();
        check_val("page_show", 32'(page_sel), wn ? 32'd2 : 32'd1);
        check_val("valid_show", 32'(bcd_valid), 32'd1);
        check_val("blink0", 32'(text_visible), 32'd1);
        check_val("bcd_show", 32'(score_bcd), 32'(exp_bcd));
    endtask

    task automatic leave_end();
        game_over = 1'b0;
        game_won  = 1'b0;
        tick();
        pulse_frame();
        check_val("page_exit", 32'(page_sel), 32'd0);
        check_val("valid_exit", 32'(bcd_valid), 32'd0);
        check_val("text_exit", 32'(text_visible), 32'd1);
        repeat (2) tick();
    endtask

    task automatic run_round(input logic [ScoreW-1:0] sc, input logic ov, input logic wn,
                             input bit early_hold, input int press_frame,
                             input bit linger, input bit fs_on_last);
        logic [1:0] exp_page;
        int         base;
        exp_page = wn ? 2'd2 : 2'd1;
        enter_end(sc, ov, wn, fs_on_last);
        base = restart_cnt;
        for (int k = 1; k <= press_frame; k++) begin
            game_over = 1'($urandom);
            game_won  = 1'($urandom);
            pulse_frame();
            check_val("blink", 32'(text_visible), 32'(blink_of(k)));
            check_val("page_hold", 32'(page_sel), 32'(exp_page));
            if (early_hold && k == 2) key = 1'b1;
            if (!early_hold && k == Hold - 1) begin
                key = 1'b1;
                tick();
                key = 1'b0;
            end
            if (k == press_frame) begin
                check_val("no_early_restart", restart_cnt, base);
                if (early_hold) begin
                    key = 1'b0;
                    tick();
                end
                key = 1'b1;
                tick();
                check_val("restart_pulse", 32'(restart_req), 32'd1);
                tick();
                check_val("restart_width", 32'(restart_req), 32'd0);
                key = 1'b0;
            end else begin
                repeat (3) tick();
            end
        end
        check_val("restart_count", restart_cnt, base + 1);
        if (linger) begin
            game_over = ov;
            game_won  = wn;
            repeat (2) begin
                pulse_frame();
                tick();
                check_val("page_linger", 32'(page_sel), 32'(exp_page));
            end
        end
        leave_end();
    endtask

    task automatic run_auto();
        int base;
        enter_end(10'd42, 1'b1, 1'b0, 1'b0);
        base = restart_cnt;
        for (int k = 1; k <= 20; k++) begin
            pulse_frame();
            repeat (3) tick();
`ifdef END_AUTO_RESTART_EN
            check_val("auto_restart", restart_cnt, base + ((k >= Auto) ? 1 : 0));
            if (k == Auto) break;
`else
            check_val("no_auto_restart", restart_cnt, base);
            check_val("blink_long", 32'(text_visible), 32'(blink_of(k)));
`endif
        end
`ifndef END_AUTO_RESTART_EN
        key = 1'b1;
        repeat (2) tick();
        key = 1'b0;
        check_val("late_confirm", restart_cnt, base + 1);
`endif
        leave_end();
    endtask

    initial begin
        int press;
        n_vec       = 0;
        n_err       = 0;
        restart_cnt = 0;
        exp_bcd     = '0;
        rst_n       = 1'b0;
        frame_start = 1'b0;
        game_over   = 1'b0;
        game_won    = 1'b0;
        score       = '0;
        key         = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check_val("rst_page", 32'(page_sel), 32'd0);
        check_val("rst_bcd", 32'(score_bcd), 32'd0);
        check_val("rst_valid", 32'(bcd_valid), 32'd0);
        check_val("rst_text", 32'(text_visible), 32'd1);
        check_val("rst_restart", 32'(restart_req), 32'd0);

        run_round(10'd1023, 1'b0, 1'b1, 1'b0, 4, 1'b1, 1'b0);
        run_round(10'd0, 1'b1, 1'b0, 1'b1, 5, 1'b0, 1'b1);
        run_round(ScoreW'($urandom_range(1023)), 1'b1, 1'b1, 1'b1, 5, 1'b1, 1'b0);

        // Abort mid-conversion: outputs must return to reset values immediately.
        score     = 10'd700;
        game_won  = 1'b1;
        pulse_frame();
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check_val("abort_page", 32'(page_sel), 32'd0);
        check_val("abort_bcd", 32'(score_bcd), 32'd0);
        check_val("abort_valid", 32'(bcd_valid), 32'd0);
        check_val("abort_text", 32'(text_visible), 32'd1);
        check_val("abort_restart", 32'(restart_req), 32'd0);
        exp_bcd  = '0;
        game_won = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        run_round(10'd999, 1'b1, 1'b0, 1'b0, 6, 1'b0, 1'b0);

        for (int r = 0; r < 6; r++) begin
            logic ov;
            logic wn;
            ov = 1'($urandom);
            wn = ov ? 1'($urandom) : 1'b1;
            press = int'($urandom_range(Hold + 3, Hold));
            run_round(ScoreW'($urandom_range(1023)), ov, wn, 1'($urandom), press,
                      1'($urandom), 1'($urandom));
        end

        run_auto();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
